clk_div_scheduler: RTL

Multi-channel clock-enable scheduler for the divider datapath. Each of NCH channels holds a programmable divide ratio and emits a one-cycle enable pulse every ratio cycles of `clk_in`, all channels phase-aligned at start. Ratios are loaded through a valid/ready config port and may be changed while running without glitching the output. Sits between the control/config logic and every downstream block that today uses a fixed divider such as the divide-by-five clock.

---
 rtl/clk_div_sched_pkg.sv | 19 +
 rtl/clk_div_scheduler_chan.sv | 108 ++++++++++
 rtl/clk_div_scheduler.sv | 81 ++++++++
 3 files changed

// File: rtl/clk_div_sched_pkg.sv
// Shared types and defaults for the clk_div_scheduler slice.
package clk_div_sched_pkg;

  localparam int unsigned NCH_DEFAULT  = 4;
  localparam int unsigned CW_DEFAULT   = 8;
  localparam int unsigned DIV_DISABLED = 0;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN
  } state_t;

  // Channel-select width; a single channel still needs a 1-bit select port.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_scheduler_chan.sv
// One scheduler channel: counter, ratio, shadow ratio, pending flag, pulse/square outputs.
// Square output is built only when CLK_DIV_SCHED_SQUARE_EN is defined.
module clk_div_chan
  import clk_div_sched_pkg::*;
#(
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          idle_i,
  input  logic          align_i,
  input  logic          run_i,
  input  logic          halt_i,
  input  logic          wr_i,
  input  logic [CW-1:0] wr_div_i,
  output logic          pending_o,
  output logic          pulse_o,
  output logic          sq_o
);

  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          pulse_q, pulse_d;
  logic          active_d;

  always_comb begin
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    cnt_d     = '0;
    if (halt_i) begin
      // Leaving the run: a write in this same cycle, else any waiting shadow, lands directly.
      if (wr_i) begin
        div_d = wr_div_i;
      end else if (pending_q) begin
        div_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (idle_i) begin
      if (wr_i) begin
        div_d = wr_div_i;
      end
    end else begin
      if (wr_i) begin
        shadow_d  = wr_div_i;
        pending_d = 1'b1;
      end
      if (run_i) begin
        if (div_q == CW'(DIV_DISABLED) || cnt_q == div_q - CW'(1)) begin
          if (pending_q) begin
            div_d     = shadow_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // Outputs are computed from the next count so they line up with the registered count.
  always_comb begin
    active_d = (align_i | run_i) & ~halt_i;
    pulse_d  = active_d && (div_d != CW'(DIV_DISABLED)) && (cnt_d == div_d - CW'(1));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_q     <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pending_o = pending_q;
  assign pulse_o   = pulse_q;

`ifdef CLK_DIV_SCHED_SQUARE_EN
  logic sq_q, sq_d;

  always_comb begin
    sq_d = active_d && (cnt_d < (div_d >> 1));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_o = sq_q;
`else
  assign sq_o = 1'b0;
`endif

endmodule

// File: rtl/clk_div_scheduler.sv
// Multi-channel clock-enable scheduler: FSM, config decode and ready reduction.
// Optional square-wave outputs are enabled with CLK_DIV_SCHED_SQUARE_EN.
module clk_div_scheduler
  import clk_div_sched_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEFAULT,
  parameter int unsigned CW  = CW_DEFAULT
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [ch_width(NCH)-1:0]     cfg_ch,
  input  logic [CW-1:0]                cfg_div,
  input  logic                         start,
  input  logic                         stop,
  output logic                         busy,
  output logic [NCH-1:0]               pulse,
  output logic [NCH-1:0]               sq_out
);

  localparam int unsigned CHW = ch_width(NCH);

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           idle_s, align_s, run_s, halt_s;
  logic           cfg_fire;
  logic [NCH-1:0] pending;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !stop) state_d = ALIGN;
      ALIGN:   state_d = stop ? IDLE : RUN;
      RUN:     if (stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_d != IDLE);
    idle_s  = (state_q == IDLE);
    align_s = (state_q == ALIGN);
    run_s   = (state_q == RUN);
    halt_s  = (state_q != IDLE) && (state_d == IDLE);
  end

  assign cfg_ready = ~|pending;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign busy      = busy_q;

  // Selects at or above NCH match no channel, so such writes are absorbed silently.
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CW (CW)
    ) u_chan (
      .clk_in    (clk_in),
      .rst       (rst),
      .idle_i    (idle_s),
      .align_i   (align_s),
      .run_i     (run_s),
      .halt_i    (halt_s),
      .wr_i      (cfg_fire && (cfg_ch == CHW'(g))),
      .wr_div_i  (cfg_div),
      .pending_o (pending[g]),
      .pulse_o   (pulse[g]),
      .sq_o      (sq_out[g])
    );
  end

endmodule
